dqs_dly_scan: RTL and testbench
===============================

# dqs_dly_scan

Automatic per-lane delay scan controller for DQS/DQ loopback calibration. For every tap `0..2**DLY_WIDTH-1` it loads the tap into all lanes' `odelay_pipe`-style delay elements and waits for the delay to settle. It then compares each lane's deserialized loopback data against a fixed 4-bit pattern and tracks the longest contiguous passing window per lane. At the end it applies the window center to each lane. It sits between the `idelay_ctrl` ready output and the per-lane OSERDES/ODELAY/ISERDES loopback paths.

## Interface
Parameters:
- `NUM_LANES`, 2, number of independent lanes scanned in parallel
- `DLY_WIDTH`, 5, delay tap width (taps `0..2**DLY_WIDTH-1`)
- `SETTLE_CYCLES`, 16, cycles waited after `dly_set` before sampling (≥1)
- `SAMPLES`, 8, consecutive compare cycles per tap (≥1)
- `PATTERN`, 4'b0101, expected 4-bit deserialized word, also driven on `pat_out`

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  single-cycle request to begin a scan; accepted only in IDLE
- `dly_ready`  in  1  `idelay_ctrl` ready signal
- `rx_data`  in  4*NUM_LANES  deserialized loopback word; lane i occupies `[4i+3:4i]`
- `pat_out`  out  4  serializer data, constant `PATTERN` (reset value `4'b0`)
- `dly_out`  out  DLY_WIDTH*NUM_LANES  per-lane delay value
- `dly_ld`  out  NUM_LANES  per-lane delay load strobe
- `dly_set`  out  1  common delay apply strobe
- `busy`  out  1  scan in progress
- `done`  out  1  scan finished; level output
- `err`  out  1  scan aborted because `dly_ready` dropped
- `found`  out  NUM_LANES  lane had at least one passing tap
- `win_start`  out  DLY_WIDTH*NUM_LANES  first tap of the best window
- `win_len`  out  (DLY_WIDTH+1)*NUM_LANES  length of the best window (0..2**DLY_WIDTH)
- `center`  out  DLY_WIDTH*NUM_LANES  applied tap

## Operation
FSM states: IDLE, WAIT_RDY, LOAD, SET, SETTLE, SAMPLE, NEXT, APPLY_LD, APPLY_SET, DONE.
- **IDLE:** on `start`, clear `done`, `err`, all per-lane results and the tap counter, assert `busy`, then go to WAIT_RDY.
- **WAIT_RDY:** stay while `dly_ready`=0; go to LOAD when it is 1.
- **LOAD:** 1 cycle. `dly_out` = tap for all lanes; `dly_ld` = all ones.
- **SET:** 1 cycle. `dly_set`=1.
- **SETTLE:** exactly SETTLE_CYCLES cycles; no comparison.
- **SAMPLE:** exactly SAMPLES cycles. Per lane, a sticky fail bit is set if `rx_data` lane ≠ PATTERN in any cycle.
- **NEXT:** 1 cycle. Per lane:
  - Pass: if `cur_len`==0, then `cur_start`=tap. `cur_len`+=1. If the new `cur_len` > `best_len`, then `best_start`=`cur_start` and `best_len`=new `cur_len`. Strict greater-than, so on a tie the earliest window is kept.
  - Fail: `cur_len`=0.
  - If tap==max, go to APPLY_LD; else tap+=1 and go to LOAD.
- **APPLY_LD:** 1 cycle. Per lane, `center` = `best_start + ((best_len-1)>>1)` when `best_len`≠0, else 0. `dly_out`=`center`; `dly_ld` all ones.
- **APPLY_SET:** 1 cycle. `dly_set`=1.
- **DONE:** `busy`=0, `done`=1, `found[i]` = (`best_len[i]`≠0). Go to IDLE the same cycle; `done` and the results hold until the next accepted `start`.
- **Abort:** if `dly_ready`=0 in any of LOAD..APPLY_SET, go to DONE with `err`=1 and `found`=0. No apply is performed.
- **Arithmetic:** the tap counter is DLY_WIDTH bits, and termination uses the tap==max compare, not wrap-around. `cur_len`/`best_len` are DLY_WIDTH+1 bits and cannot overflow.

## Timing
- **Reset values:** `rst` in any state returns the FSM to IDLE next cycle. All outputs are then 0: `busy`, `done`, `err`, `found`, `win_*`, `center`, `dly_*`, `pat_out`. `pat_out`=PATTERN from the first cycle after reset release.
- **Strobes:** `dly_ld` and `dly_set` are registered single-cycle pulses. `dly_out` is stable from LOAD through SAMPLE.
- **Start handshake:** `busy` rises the cycle after `start` is sampled. `start` while `busy`=1 is ignored.
- **Per-tap cost:** 3 + SETTLE_CYCLES + SAMPLES cycles (27 with defaults).
- **Full scan:** with `dly_ready`=1 throughout, `done` rises 2**DLY_WIDTH·(3+SETTLE_CYCLES+SAMPLES) + 4 cycles after `start` (868 with defaults). The count includes WAIT_RDY(1), APPLY_LD(1), APPLY_SET(1) and DONE(1).
- **Sampling point:** `rx_data` is sampled only in SAMPLE, at the same edge at which the comparison is made.

## Test plan
- **All taps pass:** `rx_data`=PATTERN on all lanes always. Expect `found`=all ones, `win_start`=0, `win_len`=32, `center`=15, and `done` 868 cycles after `start`.
- **Single window:** lane 0 passes taps 10..20 only (loopback model keyed on the last loaded `dly_out`). Expect `win_start`=10, `win_len`=11, `center`=15. The last `dly_out` written to lane 0 is 15, with one `dly_ld`+`dly_set` pair after the scan.
- **Two windows:** lane 1 passes 2..5 and 20..23 (tie), and separately 2..5 and 20..26. Expect `win_start`=2/`win_len`=4/`center`=3 for the tie, and `win_start`=20/`win_len`=7/`center`=23 for the second case.
- **No passing tap:** lane 0 `rx_data`=4'b1111 always. Expect `found[0]`=0, `win_len`=0, `center`=0, while lane 1 is unaffected.
- **dly_ready drop:** deassert `dly_ready` during SAMPLE of tap 7. Expect `done`=1, `err`=1, `found`=0, `busy`=0 and no APPLY strobes. A new `start` must clear `err` and run a full scan.
- **Reset mid-scan:** assert `rst` during SETTLE of tap 12. Expect all outputs 0 the next cycle; `start` held during reset is ignored. Also check that a second `start` pulsed while `busy`=1 does not restart the scan or change the `done` timing.

Source files
------------

// File: rtl/dqs_dly_scan.sv
// dqs_dly_scan: per-lane delay tap sweep that finds the widest passing loopback
// window on each lane and applies its center tap.
module dqs_dly_scan #(
    parameter int         NUM_LANES     = 2,
    parameter int         DLY_WIDTH     = 5,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         SAMPLES       = 8,
    parameter logic [3:0] PATTERN       = 4'b0101
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             dly_ready,
    input  logic [4*NUM_LANES-1:0]           rx_data,
    output logic [3:0]                       pat_out,
    output logic [DLY_WIDTH*NUM_LANES-1:0]   dly_out,
    output logic [NUM_LANES-1:0]             dly_ld,
    output logic                             dly_set,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [NUM_LANES-1:0]             found,
    output logic [DLY_WIDTH*NUM_LANES-1:0]   win_start,
    output logic [(DLY_WIDTH+1)*NUM_LANES-1:0] win_len,
    output logic [DLY_WIDTH*NUM_LANES-1:0]   center
);
    localparam int CMAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int LW = DLY_WIDTH + 1;
    localparam logic [DLY_WIDTH-1:0] TAP_MAX = '1;
    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, LOAD, SET, SETTLE, SAMPLE, NEXT, APPLY_LD, APPLY_SET, DONE
    } state_t;
    state_t                               state_q, state_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [DLY_WIDTH-1:0]                 tap_q, tap_d;
    logic [NUM_LANES-1:0][DLY_WIDTH-1:0]  cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [NUM_LANES-1:0][DLY_WIDTH-1:0]  center_q, center_d, dly_out_q, dly_out_d;
    logic [NUM_LANES-1:0][LW-1:0]         cur_len_q, cur_len_d, best_len_q, best_len_d;
    logic [NUM_LANES-1:0]                 fail_q, fail_d, found_q, found_d, dly_ld_q, dly_ld_d;
    logic                                 dly_set_q, dly_set_d, busy_q, busy_d;
    logic                                 done_q, done_d, err_q, err_d;
    logic [3:0]                           pat_q;
    logic                                 accept, abort;
    assign accept = (state_q == IDLE) && start;
    assign abort  = !dly_ready && (state_q inside {LOAD, SET, SETTLE, SAMPLE, NEXT, APPLY_LD, APPLY_SET});
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = WAIT_RDY;
            WAIT_RDY:  if (dly_ready) state_d = LOAD;
            LOAD:      state_d = SET;
            SET:       state_d = SETTLE;
            SETTLE:    if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
            SAMPLE:    if (cnt_q == CW'(SAMPLES - 1)) state_d = NEXT;
            NEXT:      state_d = (tap_q == TAP_MAX) ? APPLY_LD : LOAD;
            APPLY_LD:  state_d = APPLY_SET;
            APPLY_SET: state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort) state_d = DONE;
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    end
    // Window tracking: a passing tap extends the current run; the best run only
    // moves on a strictly longer run, so ties keep the earliest window.
    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        center_d     = center_q;
        fail_d       = fail_q;
        found_d      = found_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (state_q == SAMPLE) fail_d[i] = fail_q[i] | (rx_data[4*i +: 4] != PATTERN);
            if (state_q == NEXT) begin
                fail_d[i] = 1'b0;
                if (fail_q[i]) begin
                    cur_len_d[i] = '0;
                end else begin
                    cur_start_d[i] = (cur_len_q[i] == '0) ? tap_q : cur_start_q[i];
                    cur_len_d[i]   = cur_len_q[i] + LW'(1);
                    if (cur_len_d[i] > best_len_q[i]) begin
                        best_start_d[i] = cur_start_d[i];
                        best_len_d[i]   = cur_len_d[i];
                    end
                end
            end
            if (state_d == APPLY_LD)
                center_d[i] = (best_len_d[i] != '0) ?
                    DLY_WIDTH'(LW'(best_start_d[i]) + ((best_len_d[i] - LW'(1)) >> 1)) : '0;
            if (state_q == DONE) found_d[i] = !err_q && (best_len_q[i] != '0);
            if (accept) begin
                cur_start_d[i]  = '0;
                cur_len_d[i]    = '0;
                best_start_d[i] = '0;
                best_len_d[i]   = '0;
                center_d[i]     = '0;
                fail_d[i]       = 1'b0;
                found_d[i]      = 1'b0;
            end
        end
    end
    // Strobes and dly_out are registered from the next state so they line up
    // with the state they belong to.
    always_comb begin
        tap_d     = accept ? '0 : (state_q == NEXT && state_d == LOAD) ? tap_q + DLY_WIDTH'(1) : tap_q;
        busy_d    = accept ? 1'b1 : (state_q == DONE) ? 1'b0 : busy_q;
        done_d    = accept ? 1'b0 : (state_q == DONE) ? 1'b1 : done_q;
        err_d     = accept ? 1'b0 : abort ? 1'b1 : err_q;
        dly_ld_d  = {NUM_LANES{state_d == LOAD || state_d == APPLY_LD}};
        dly_set_d = (state_d == SET) || (state_d == APPLY_SET);
        dly_out_d = dly_out_q;
        for (int i = 0; i < NUM_LANES; i++)
            dly_out_d[i] = (state_d == LOAD) ? tap_d : (state_d == APPLY_LD) ? center_d[i] : dly_out_q[i];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q        <= '0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            center_q     <= '0;
            fail_q       <= '0;
            found_q      <= '0;
            dly_out_q    <= '0;
            dly_ld_q     <= '0;
            dly_set_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pat_q        <= '0;
        end else begin
            tap_q        <= tap_d;
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            center_q     <= center_d;
            fail_q       <= fail_d;
            found_q      <= found_d;
            dly_out_q    <= dly_out_d;
            dly_ld_q     <= dly_ld_d;
            dly_set_q    <= dly_set_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pat_q        <= PATTERN;
        end
    end
    assign pat_out   = pat_q;
    assign dly_out   = dly_out_q;
    assign dly_ld    = dly_ld_q;
    assign dly_set   = dly_set_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign found     = found_q;
    assign win_start = best_start_q;
    assign win_len   = best_len_q;
    assign center    = center_q;
endmodule

// File: tb/tb_dqs_dly_scan.sv
// tb_dqs_dly_scan: directed scans against a tap-keyed loopback model, expected
// results queued at start and compared when done rises.
module tb_dqs_dly_scan;
    localparam int NL = 2;
    localparam int DW = 5;
    logic                 clk = 1'b0;
    logic                 rst, start, dly_ready;
    logic [4*NL-1:0]      rx_data;
    logic [3:0]           pat_out;
    logic [DW*NL-1:0]     dly_out, win_start, center;
    logic [NL-1:0]        dly_ld, found;
    logic                 dly_set, busy, done, err;
    logic [(DW+1)*NL-1:0] win_len;
    logic [31:0]          mask [NL];
    logic [DW-1:0]        ld_tap [NL];
    int                   ld_cnt = 0, set_cnt = 0, n_chk = 0, n_fail = 0;
    typedef struct {
        logic [NL-1:0]        found;
        logic [DW*NL-1:0]     ws, ctr;
        logic [(DW+1)*NL-1:0] wl;
        logic                 err;
        int                   lat;
        int                   lds;
    } exp_t;
    exp_t sbq [$];

    dqs_dly_scan dut (
        .clk(clk), .rst(rst), .start(start), .dly_ready(dly_ready), .rx_data(rx_data),
        .pat_out(pat_out), .dly_out(dly_out), .dly_ld(dly_ld), .dly_set(dly_set),
        .busy(busy), .done(done), .err(err), .found(found), .win_start(win_start),
        .win_len(win_len), .center(center)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) if (dly_ld[i]) ld_tap[i] <= dly_out[DW*i +: DW];
        if (dly_ld[0]) ld_cnt <= ld_cnt + 1;
        if (dly_set) set_cnt <= set_cnt + 1;
    end

    always_comb begin
        rx_data = '0;
        for (int i = 0; i < NL; i++) rx_data[4*i +: 4] = mask[i][ld_tap[i]] ? 4'b0101 : 4'b1111;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // drop_at/dup_at: negedge index after start at which dly_ready drops / start is re-pulsed
    task automatic scan(input logic [31:0] m0, input logic [31:0] m1, input int drop_at, input int dup_at);
        exp_t e;
        int n, l0, s0, bs, bl, len;
        mask[0] = m0;
        mask[1] = m1;
        e.found = '0; e.ws = '0; e.wl = '0; e.ctr = '0;
        for (int l = 0; l < NL; l++) begin
            bs = 0;
            bl = 0;
            for (int s = 0; s < 32; s++) begin
                len = 0;
                while (s + len < 32 && mask[l][s+len]) len++;
                if (len > bl) begin bl = len; bs = s; end
            end
            e.found[l] = (bl != 0);
            e.ws[DW*l +: DW] = DW'(bs);
            e.wl[(DW+1)*l +: DW+1] = (DW+1)'(bl);
            e.ctr[DW*l +: DW] = (bl != 0) ? DW'(bs + (bl - 1) / 2) : '0;
        end
        e.err = (drop_at > 0);
        e.lat = e.err ? 211 : 868;
        e.lds = e.err ? 8 : 33;
        if (e.err) begin e.found = '0; e.ctr = '0; end
        sbq.push_back(e);
        l0 = ld_cnt;
        s0 = set_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        chk("busy_rise", busy, 1);
        chk("done_clear", done, 0);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            start = (n == dup_at);
            if (n == drop_at) dly_ready = 1'b0;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        e = sbq.pop_front();
        chk("latency", n - 1, e.lat);
        chk("err", err, e.err);
        chk("found", found, e.found);
        chk("center", center, e.ctr);
        chk("busy_fall", busy, 0);
        chk("ld_pulses", ld_cnt - l0, e.lds);
        chk("set_pulses", set_cnt - s0, e.lds);
        if (!e.err) begin
            chk("win_start", win_start, e.ws);
            chk("win_len", win_len, e.wl);
            chk("applied_l0", ld_tap[0], e.ctr[DW-1:0]);
            chk("applied_l1", ld_tap[1], e.ctr[2*DW-1:DW]);
        end
        dly_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_win_start"}, win_start, 0);
        chk({tag, "_win_len"}, win_len, 0);
        chk({tag, "_center"}, center, 0);
        chk({tag, "_dly_out"}, dly_out, 0);
        chk({tag, "_dly_ld"}, dly_ld, 0);
        chk({tag, "_dly_set"}, dly_set, 0);
        chk({tag, "_pat_out"}, pat_out, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dly_ready = 1'b1;
        mask[0] = '1;
        mask[1] = '1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("pat_out", pat_out, 4'b0101);
        chk("idle_busy", busy, 0);
        scan('1, '1, 0, 0);
        scan(rng(10, 20), '1, 0, 0);
        scan('1, rng(2, 5) | rng(20, 23), 0, 0);
        scan('1, rng(2, 5) | rng(20, 26), 0, 0);
        scan('0, '1, 0, 0);
        scan('1, '1, 210, 0);
        scan('1, '1, 0, 0);
        // Reset during SETTLE of tap 12 with start held high
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (329) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_pat", pat_out, 4'b0101);
        scan(rng(10, 20), rng(3, 29), 0, 100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
